reg_alu_sequencer: RTL
======================

# reg_alu_sequencer

Single-clock control sequencer that drives the register-file/ALU datapath with the same step signals an operator would otherwise toggle by hand. It accepts one RV32 R-type instruction word, decodes the register addresses and the 4-bit ALU operation, and issues one-cycle read-register, ALU-latch and write-back strobes in order. It sits between the instruction source and the datapath top, whose `clk_RR`, `clk_F` and `clk_WB` inputs it feeds through clock-enable strobes.

## Interface

- `PHASE_CYCLES`, default 1, length in clocks of each of the RR, EX and WB phases; legal range 1..16.

Reset is asynchronous and active-low.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `start` in 1: launch request, sampled only in IDLE.
- `inst` in 32: instruction word, captured on the accepting edge.
- `busy` out 1: high from DECODE through DONE.
- `done` out 1: one-cycle pulse at the end of each accepted instruction.
- `illegal` out 1: set when the captured instruction is not a supported R-type; held until the next accepted `start`.
- `R_Addr_A` out 5: rs1 = `inst[19:15]`.
- `R_Addr_B` out 5: rs2 = `inst[24:20]`.
- `W_Addr` out 5: rd = `inst[11:7]`.
- `ALU_OP` out 4: decoded operation.
- `Reg_Write` out 1: register-file write enable.
- `rr_en` out 1: read-register latch strobe.
- `f_en` out 1: ALU result latch strobe.
- `wb_en` out 1: write-back strobe.

## Operation

- **States:** IDLE, DECODE, RR, EX, WB, DONE.
- **IDLE:**
  - If `start` is 1 at a rising edge, capture `inst` and go to DECODE.
  - Otherwise stay in IDLE.
- **DECODE** (1 cycle):
  - Drive `R_Addr_A`, `R_Addr_B`, `W_Addr` and `ALU_OP` from the captured word.
  - Clear or set `illegal`.
  - If legal, go to RR; if illegal, go directly to DONE.
- **Legality:** the instruction is legal only when both hold:
  - opcode `inst[6:0]` = 7'b0110011;
  - funct7 = 7'b0000000, or funct7 = 7'b0100000 with funct3 equal to 3'b000 or 3'b101.
- **ALU_OP encoding:** `ALU_OP = {funct7[5], funct3}`, giving ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101.
- **Output hold:** address outputs and `ALU_OP` keep their DECODE value until the next accepted `start`.
- **RR, EX, WB phases:**
  - Each phase lasts `PHASE_CYCLES` clocks, counted by a 4-bit phase counter.
  - The phase's strobe (`rr_en`, `f_en`, `wb_en` respectively) is high on the first cycle of the phase only.
- **Reg_Write:**
  - High for every cycle of WB when `W_Addr` != 0.
  - Stays 0 when `W_Addr` = 0; `wb_en` still pulses, so an x0 write is suppressed.
- **DONE** (1 cycle): `done` = 1, then return to IDLE.
- **Mutual exclusion:** at most one of `rr_en`, `f_en`, `wb_en` is high in any cycle. None of them ever pulses for an illegal instruction.

## Timing

- **Reset values** (applied asynchronously while `rst_n` = 0):
  - State is IDLE; phase counter is 0.
  - `busy`, `done`, `illegal`, `Reg_Write`, `rr_en`, `f_en` and `wb_en` are all 0.
  - All address outputs and `ALU_OP` are 0.
- **Reset release:** the first `start` can be accepted at the first rising edge after `rst_n` rises.
- **Legal latency**, with `start` accepted at edge k:
  - DECODE is cycle k+1.
  - `rr_en` is high in cycle k+2.
  - `f_en` is high in cycle k+2+P.
  - `wb_en` is high in cycle k+2+2P.
  - `done` is high in cycle k+2+3P, where P = `PHASE_CYCLES`.
- **Illegal latency:** `done` and `illegal` are both high in cycle k+2.
- **Back-to-back:** `start` is ignored while `busy` = 1, including the DONE cycle. The earliest next acceptance is the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- **Reset mid-operation:** all outputs drop immediately, with no further strobes. A partially completed instruction is abandoned and never written back.

## Test plan

1. **ADD:** `inst` = 0x002081B3 (add x3,x1,x2), P=1, `start` at edge k.
   - Addresses read 1/2/3 and `ALU_OP` = 0000 from k+1.
   - `rr_en` at k+2, `f_en` at k+3.
   - `wb_en` with `Reg_Write` = 1 at k+4.
   - `done` at k+5; `illegal` = 0.
2. **SUB:** `inst` = 0x407302B3 (sub x5,x6,x7).
   - `ALU_OP` = 1000; addresses read 6/7/5.
   - Same strobe timing as scenario 1.
3. **Write to x0:** `inst` = 0x00208033 (add x0,x1,x2).
   - `wb_en` pulses at k+4.
   - `Reg_Write` stays 0 throughout.
4. **Illegal instruction:** `inst` = 0x00100093 (addi).
   - No `rr_en`, `f_en` or `wb_en` pulse.
   - `done` = 1 and `illegal` = 1 at k+2.
   - A following legal `start` clears `illegal` in its DECODE cycle.
5. **Long phases:** P=3, `inst` = 0x002081B3.
   - `rr_en` at k+2, `f_en` at k+5.
   - `wb_en` at k+8; `Reg_Write` high during k+8..k+10.
   - `done` at k+11.
6. **Busy and reset:**
   - `start` held high for the whole instruction: exactly one instruction per IDLE acceptance.
   - `rst_n` pulled low during EX: all outputs are 0 within the same cycle, with no `wb_en`.
   - After release, a new `start` runs normally.

Source files
------------

// File: rtl/reg_alu_sequencer_if.sv
// reg_alu_sequencer_if
//
// Bus between the instruction source (master) and reg_alu_sequencer (slave).
//   start, inst          : launch request and the RV32 R-type word to run
//   busy, done, illegal  : sequencer status
//   R_Addr_A/B, W_Addr   : rs1 / rs2 / rd register addresses
//   ALU_OP               : {funct7[5], funct3}
//   Reg_Write            : register-file write enable
//   rr_en, f_en, wb_en   : one-cycle clock-enable strobes for clk_RR, clk_F, clk_WB
interface reg_alu_sequencer_if;
    logic        start;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic [3:0]  ALU_OP;
    logic        Reg_Write;
    logic        rr_en;
    logic        f_en;
    logic        wb_en;

    modport master (
        output start, inst,
        input  busy, done, illegal, R_Addr_A, R_Addr_B, W_Addr, ALU_OP,
               Reg_Write, rr_en, f_en, wb_en
    );

    modport slave (
        input  start, inst,
        output busy, done, illegal, R_Addr_A, R_Addr_B, W_Addr, ALU_OP,
               Reg_Write, rr_en, f_en, wb_en
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer
//
// Sequences one RV32 R-type instruction through the register-file/ALU
// datapath: IDLE -> DECODE -> RR -> EX -> WB -> DONE -> IDLE. Illegal words
// skip straight from DECODE to DONE with no datapath strobes.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : reg_alu_sequencer_if.slave (start/inst in; status, addresses,
//            ALU_OP, Reg_Write and the rr_en/f_en/wb_en strobes out)
//
// Parameter:
//   PHASE_CYCLES : clocks spent in each of RR, EX and WB (1..16)
module reg_alu_sequencer #(
    parameter int unsigned PHASE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_alu_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_RR     = 3'd2;
    localparam logic [2:0] S_EX     = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] PHASE_LAST = 4'(PHASE_CYCLES - 1);

    logic [2:0]  state;
    logic [3:0]  phase_cnt;
    logic [31:0] inst_q;
    logic        illegal_q;
    logic        legal;
    logic        phase_end;
    logic        first_cycle;

    always_comb begin
        legal = 1'b0;
        if (inst_q[6:0] == 7'b0110011) begin
            if (inst_q[31:25] == 7'b0000000)
                legal = 1'b1;
            else if (inst_q[31:25] == 7'b0100000 &&
                     (inst_q[14:12] == 3'b000 || inst_q[14:12] == 3'b101))
                legal = 1'b1;
        end
    end

    assign phase_end   = (phase_cnt == PHASE_LAST);
    assign first_cycle = (phase_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            inst_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // illegal is cleared on acceptance so it already reads
                        // 0 during DECODE of a new instruction.
                        inst_q    <= bus.inst;
                        illegal_q <= 1'b0;
                        phase_cnt <= '0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    illegal_q <= ~legal;
                    phase_cnt <= '0;
                    state     <= legal ? S_RR : S_DONE;
                end
                S_RR, S_EX, S_WB: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        case (state)
                            S_RR:    state <= S_EX;
                            S_EX:    state <= S_WB;
                            default: state <= S_DONE;
                        endcase
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Addresses and ALU_OP come straight from the captured word, so they hold
    // until the next acceptance and fall to 0 with reset.
    assign bus.R_Addr_A  = inst_q[19:15];
    assign bus.R_Addr_B  = inst_q[24:20];
    assign bus.W_Addr    = inst_q[11:7];
    assign bus.ALU_OP    = {inst_q[30], inst_q[14:12]};

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.illegal   = illegal_q;
    assign bus.rr_en     = (state == S_RR) && first_cycle;
    assign bus.f_en      = (state == S_EX) && first_cycle;
    assign bus.wb_en     = (state == S_WB) && first_cycle;
    assign bus.Reg_Write = (state == S_WB) && (inst_q[11:7] != 5'd0);

endmodule
